tcdm_bank_arbiter: RTL and testbench
====================================

Name: tcdm_bank_arbiter

Overview:
- Shares one single-ported TCDM SRAM bank (1-cycle read latency) between NumReq requesters, e.g. the local cores of a tile plus the remote-group port.
- Arbitrates requests round-robin and drives the bank.
- Captures bank responses in a credit-protected response buffer.
- Returns each response, with its metadata (meta_id/core_id/amo payload), to the requester that issued it.

Parameters:
- NumReq, 4, number of requesters (≥2)
- AddrWidth, 8, bank word address width (TCDMAddrMemWidth for 1 KiB banks)
- DataWidth, 32, data width
- MetaWidth, 8, opaque per-request tag, returned unchanged
- RespDepth, 3, response buffer entries (≥2; 3 gives full throughput)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  NumReq  per-requester request valid
- req_ready_o  out  NumReq  per-requester grant/accept
- req_addr_i  in  NumReq*AddrWidth  word addresses
- req_wen_i  in  NumReq  write enable
- req_be_i  in  NumReq*DataWidth/8  byte enables
- req_wdata_i  in  NumReq*DataWidth  write data
- req_meta_i  in  NumReq*MetaWidth  request tags
- resp_valid_o  out  NumReq  per-requester response valid
- resp_ready_i  in  NumReq  per-requester response ready
- resp_rdata_o  out  DataWidth  response data (shared bus)
- resp_meta_o  out  MetaWidth  response tag (shared bus)
- bank_req_o  out  1  bank access strobe
- bank_we_o  out  1  bank write enable
- bank_addr_o  out  AddrWidth  bank address
- bank_be_o  out  DataWidth/8  bank byte enables
- bank_wdata_o  out  DataWidth  bank write data
- bank_rdata_i  in  DataWidth  bank read data, valid the cycle after bank_req_o

Behaviour:
- Reset (asynchronous, any time):
  - rr_q=0, inflight_q=0, buffer count=0, read and write pointers=0.
  - All outputs 0 during and after reset; any in-flight access is dropped.
- Credit: issue_ok = (count_q + inflight_q < RespDepth). A pop in the same cycle gives no credit.
- Arbitration (combinational):
  - If issue_ok, grant the first valid index at or after rr_q, wrapping modulo NumReq.
  - Exactly one req_ready_o bit is high on a grant; all are 0 otherwise.
  - req_ready_o does not depend on resp_ready_i in the same cycle.
- Handshake: valid&ready is the accept.
  - In the grant cycle: bank_req_o=1 and the bank_* outputs mirror the granted requester's fields.
  - Without a grant, bank_* outputs are 0.
- Round-robin pointer: on a grant g, rr_q <= (g+1) mod NumReq. No grant leaves rr_q unchanged.
- In-flight stage:
  - On a grant, inflight_q<=1 and idx/meta/wen are registered; otherwise inflight_q<=0.
- Push: at the end of a cycle with inflight_q=1, push {bank_rdata_i (0 for writes), meta, idx} into the buffer.
  - Writes also return a response so every request is acknowledged in order.
- Latency: request accepted in cycle T -> resp_valid_o[idx] high from T+2.
- Output:
  - The buffer head drives resp_rdata_o/resp_meta_o, and resp_valid_o has only bit head.idx set.
  - Pop on resp_ready_i[head.idx]. Other ready bits are ignored.
  - Head-of-line blocking across requesters is intended.
- Buffer:
  - Circular, pointers wrap at RespDepth.
  - Push and pop in the same cycle leave count unchanged.
  - Overflow is impossible by the credit rule; assert count_q ≤ RespDepth.
- Throughput:
  - With RespDepth=3 and responses always ready: one grant per cycle, sustained.
  - Responses never ready: at most RespDepth accepts, then req_ready_o=0 until a pop.
- Ordering: responses leave strictly in grant order.

Test Plan:
- Single read: preload bank word 0x12=0xCAFEF00D; requester 2 reads 0x12 with meta 0x5A at T -> bank_req_o=1, bank_addr_o=0x12 at T; resp_valid_o=4'b0100, rdata 0xCAFEF00D, meta 0x5A at T+2.
- Round-robin: all 4 requesters hold valid, responses always ready -> grants 0,1,2,3,0,1 on consecutive cycles with no bubble.
- Wrap-around: rr_q=3 after granting requester 2; only requesters 1 and 3 valid -> grant 3, then 1.
- Backpressure: resp_ready_i=0, requester 0 issues continuously -> exactly 3 accepts, req_ready_o=0 afterwards. Raising resp_ready_i[0] for one cycle pops one entry; the next grant occurs the cycle after.
- Write ack: requester 1 writes 0xFFFFFFFF with be=4'b0011 to address 0x07 -> bank_we_o=1, bank_be_o=4'b0011; response with rdata 0 and matching meta at T+2. A follow-up read of 0x07 returns 0x0000FFFF (bank initially 0).
- Reset mid-operation: assert rst_i with 2 buffered and 1 in-flight response -> all resp_valid_o and bank_req_o go to 0 immediately. After release, the first grant goes to the lowest valid index (rr_q=0).

Source files
------------

// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter sharing one single-ported TCDM bank (1-cycle read latency)
// between NumReq requesters, with a credit-protected in-order response buffer.
module tcdm_bank_arbiter #(
    parameter int NumReq    = 4,
    parameter int AddrWidth = 8,
    parameter int DataWidth = 32,
    parameter int MetaWidth = 8,
    parameter int RespDepth = 3
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumReq-1:0]                 req_valid_i,
    output logic [NumReq-1:0]                 req_ready_o,
    input  logic [NumReq*AddrWidth-1:0]       req_addr_i,
    input  logic [NumReq-1:0]                 req_wen_i,
    input  logic [NumReq*(DataWidth/8)-1:0]   req_be_i,
    input  logic [NumReq*DataWidth-1:0]       req_wdata_i,
    input  logic [NumReq*MetaWidth-1:0]       req_meta_i,
    output logic [NumReq-1:0]                 resp_valid_o,
    input  logic [NumReq-1:0]                 resp_ready_i,
    output logic [DataWidth-1:0]              resp_rdata_o,
    output logic [MetaWidth-1:0]              resp_meta_o,
    output logic                              bank_req_o,
    output logic                              bank_we_o,
    output logic [AddrWidth-1:0]              bank_addr_o,
    output logic [DataWidth/8-1:0]            bank_be_o,
    output logic [DataWidth-1:0]              bank_wdata_o,
    input  logic [DataWidth-1:0]              bank_rdata_i
);
    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int BeW  = DataWidth / 8;
    localparam int PtrW = $clog2(RespDepth);
    localparam int CntW = $clog2(RespDepth + 1);
    localparam logic [CntW:0] Depth = (CntW + 1)'(RespDepth);

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(RespDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [IdxW-1:0]      rr_q, rr_d;
    logic                 inflight_q;
    logic [IdxW-1:0]      infl_idx_q;
    logic [MetaWidth-1:0] infl_meta_q;
    logic                 infl_wen_q;
    logic [CntW-1:0]      count_q, count_d;
    logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;

    logic [DataWidth-1:0] buf_data_q [RespDepth];
    logic [MetaWidth-1:0] buf_meta_q [RespDepth];
    logic [IdxW-1:0]      buf_idx_q  [RespDepth];

    logic [IdxW-1:0] gnt_idx, cand, head_idx;
    logic            found, issue_ok, gnt, push, pop, buf_valid;

    // Credit counts both buffered and in-flight responses; a same-cycle pop is not credited.
    assign issue_ok = ({1'b0, count_q} + {{CntW{1'b0}}, inflight_q}) < Depth;
    assign gnt      = found && issue_ok && !rst_i;

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < NumReq; i++) begin
            cand = IdxW'((int'(rr_q) + i) % NumReq);
            if (!found && req_valid_i[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready_o  = '0;
        bank_req_o   = 1'b0;
        bank_we_o    = 1'b0;
        bank_addr_o  = '0;
        bank_be_o    = '0;
        bank_wdata_o = '0;
        rr_d         = rr_q;
        if (gnt) begin
            req_ready_o[gnt_idx] = 1'b1;
            bank_req_o   = 1'b1;
            bank_we_o    = req_wen_i[gnt_idx];
            bank_addr_o  = req_addr_i[gnt_idx*AddrWidth +: AddrWidth];
            bank_be_o    = req_be_i[gnt_idx*BeW +: BeW];
            bank_wdata_o = req_wdata_i[gnt_idx*DataWidth +: DataWidth];
            rr_d         = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign push      = inflight_q;
    assign buf_valid = (count_q != '0);
    assign head_idx  = buf_idx_q[rptr_q];
    assign pop       = buf_valid && resp_ready_i[head_idx];

    always_comb begin
        resp_valid_o = '0;
        resp_rdata_o = '0;
        resp_meta_o  = '0;
        if (buf_valid) begin
            resp_valid_o[head_idx] = 1'b1;
            resp_rdata_o = buf_data_q[rptr_q];
            resp_meta_o  = buf_meta_q[rptr_q];
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            rr_q       <= rr_d;
            inflight_q <= gnt;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // Payload registers carry no reset; they are only observed behind inflight_q / count_q.
    always_ff @(posedge clk_i) begin
        if (gnt) begin
            infl_idx_q  <= gnt_idx;
            infl_meta_q <= req_meta_i[gnt_idx*MetaWidth +: MetaWidth];
            infl_wen_q  <= req_wen_i[gnt_idx];
        end
        if (push) begin
            buf_data_q[wptr_q] <= infl_wen_q ? '0 : bank_rdata_i;
            buf_meta_q[wptr_q] <= infl_meta_q;
            buf_idx_q[wptr_q]  <= infl_idx_q;
        end
    end

    always @(posedge clk_i) begin
        if (!rst_i) assert ({1'b0, count_q} <= Depth);
    end

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Directed bench for tcdm_bank_arbiter: SRAM bank model, reference memory and
// an in-order response scoreboard filled on every accept.
module tb_tcdm_bank_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MW = 8;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [N-1:0]    req_valid, req_ready, req_wen, resp_valid, resp_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*4-1:0]  req_be;
    logic [N*DW-1:0] req_wdata;
    logic [N*MW-1:0] req_meta;
    logic [DW-1:0]   resp_rdata, bank_wdata, bank_rdata;
    logic [MW-1:0]   resp_meta;
    logic            bank_req, bank_we;
    logic [AW-1:0]   bank_addr;
    logic [3:0]      bank_be;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]    idx;
        logic [MW-1:0] meta;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    logic [DW-1:0] bank_mem [256];
    logic [DW-1:0] ref_mem  [256];

    always #5 clk = ~clk;

    tcdm_bank_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW), .MetaWidth(MW), .RespDepth(3)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_wen_i(req_wen), .req_be_i(req_be), .req_wdata_i(req_wdata), .req_meta_i(req_meta),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_meta_o(resp_meta),
        .bank_req_o(bank_req), .bank_we_o(bank_we), .bank_addr_o(bank_addr),
        .bank_be_o(bank_be), .bank_wdata_o(bank_wdata), .bank_rdata_i(bank_rdata)
    );

    // Single-ported SRAM, read data one cycle after the strobe.
    always @(posedge clk) begin
        if (bank_req) begin
            if (bank_we) begin
                for (int b = 0; b < 4; b++)
                    if (bank_be[b]) bank_mem[bank_addr][8*b +: 8] = bank_wdata[8*b +: 8];
            end else begin
                bank_rdata <= bank_mem[bank_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare the response head, then record this cycle's accepts.
    always @(negedge clk) begin
        exp_t e;
        logic [AW-1:0] a;
        if (rst_i) begin
            sb.delete();
        end else begin
            if (resp_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("resp_unexpected", 64'(resp_valid), 64'h0);
                end else begin
                    e = sb[0];
                    chk("sb_valid", 64'(resp_valid), 64'(4'b0001 << e.idx));
                    chk("sb_rdata", 64'(resp_rdata), 64'(e.data));
                    chk("sb_meta",  64'(resp_meta),  64'(e.meta));
                    if ((resp_valid & resp_ready) != '0) void'(sb.pop_front());
                end
            end
            for (int r = 0; r < N; r++) begin
                if (req_valid[r] && req_ready[r]) begin
                    a      = req_addr[r*AW +: AW];
                    e.idx  = 2'(r);
                    e.meta = req_meta[r*MW +: MW];
                    if (req_wen[r]) begin
                        e.data = '0;
                        for (int b = 0; b < 4; b++)
                            if (req_be[r*4 + b]) ref_mem[a][8*b +: 8] = req_wdata[r*DW + 8*b +: 8];
                    end else begin
                        e.data = ref_mem[a];
                    end
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [AW-1:0] a, input logic w,
                           input logic [3:0] be, input logic [DW-1:0] d, input logic [MW-1:0] m);
        req_addr[r*AW +: AW]  = a;
        req_wen[r]            = w;
        req_be[r*4 +: 4]      = be;
        req_wdata[r*DW +: DW] = d;
        req_meta[r*MW +: MW]  = m;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            bank_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        bank_mem[8'h12] = 32'hCAFEF00D; ref_mem[8'h12] = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            bank_mem[8'h20 + i] = 32'h1111_0000 * (i + 1) + i;
            ref_mem[8'h20 + i]  = 32'h1111_0000 * (i + 1) + i;
        end
        bank_rdata = '0;

        rst_i      = 1'b1;
        resp_ready = 4'hF;
        req_valid  = 4'hF;
        for (int r = 0; r < N; r++) set_req(r, AW'(8'h20 + r), 1'b0, 4'hF, '0, MW'(8'h40 + r));
        @(negedge clk);
        chk("rst_ready",     64'(req_ready), 64'h0);
        chk("rst_bank_req",  64'(bank_req), 64'h0);
        chk("rst_bank_addr", 64'(bank_addr), 64'h0);
        chk("rst_resp",      64'(resp_valid), 64'h0);

        step(); rst_i = 1'b0; req_valid = '0;
        @(negedge clk);
        chk("idle_ready", 64'(req_ready), 64'h0);

        // Single read by requester 2
        step(); set_req(2, 8'h12, 1'b0, 4'hF, '0, 8'h5A); req_valid = 4'b0100;
        @(negedge clk);
        chk("rd_ready",     64'(req_ready), 64'b0100);
        chk("rd_bank_req",  64'(bank_req), 64'h1);
        chk("rd_bank_addr", 64'(bank_addr), 64'h12);
        chk("rd_bank_we",   64'(bank_we), 64'h0);
        step(); req_valid = '0;
        @(negedge clk);
        chk("rd_resp_t1", 64'(resp_valid), 64'h0);
        step();
        @(negedge clk);
        chk("rd_resp_valid", 64'(resp_valid), 64'b0100);
        chk("rd_resp_rdata", 64'(resp_rdata), 64'hCAFEF00D);
        chk("rd_resp_meta",  64'(resp_meta), 64'h5A);

        // Wrap-around: pointer at 3, requesters 1 and 3 valid
        step(); set_req(1, 8'h21, 1'b0, 4'hF, '0, 8'h61); set_req(3, 8'h23, 1'b0, 4'hF, '0, 8'h63);
        req_valid = 4'b1010;
        @(negedge clk);
        chk("wrap_g0", 64'(req_ready), 64'b1000);
        step();
        @(negedge clk);
        chk("wrap_g1", 64'(req_ready), 64'b0010);
        step(); req_valid = 4'b1000;
        @(negedge clk);
        chk("align_g3", 64'(req_ready), 64'b1000);

        // Round-robin with all requesters valid, no bubbles
        step();
        for (int r = 0; r < N; r++) set_req(r, AW'(8'h20 + r), 1'b0, 4'hF, '0, MW'(8'h80 + r));
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            if (k != 0) step();
            @(negedge clk);
            chk($sformatf("rr_g%0d", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
        end
        step(); req_valid = '0;
        repeat (4) step();

        // Backpressure: non-head ready bits must not pop
        resp_ready = 4'b1110; set_req(0, 8'h22, 1'b0, 4'hF, '0, 8'hB0); req_valid = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            if (k != 0) step();
            @(negedge clk);
            chk($sformatf("bp_acc%0d", k), 64'(req_ready), (k < 3) ? 64'h1 : 64'h0);
        end
        step(); resp_ready = 4'b0001;
        @(negedge clk);
        chk("bp_pop_cycle", 64'(req_ready), 64'h0);
        step(); resp_ready = 4'b1110;
        @(negedge clk);
        chk("bp_regrant", 64'(req_ready), 64'h1);
        step();
        @(negedge clk);
        chk("bp_full_again", 64'(req_ready), 64'h0);
        step(); req_valid = '0; resp_ready = 4'hF;
        repeat (5) step();

        // Write acknowledge, then read-back of the partial write
        set_req(1, 8'h07, 1'b1, 4'b0011, 32'hFFFFFFFF, 8'h77); req_valid = 4'b0010;
        @(negedge clk);
        chk("wr_ready",     64'(req_ready), 64'b0010);
        chk("wr_bank_we",   64'(bank_we), 64'h1);
        chk("wr_bank_be",   64'(bank_be), 64'b0011);
        chk("wr_bank_addr", 64'(bank_addr), 64'h07);
        chk("wr_bank_data", 64'(bank_wdata), 64'hFFFFFFFF);
        step(); req_valid = '0;
        step();
        @(negedge clk);
        chk("wr_resp_valid", 64'(resp_valid), 64'b0010);
        chk("wr_resp_rdata", 64'(resp_rdata), 64'h0);
        chk("wr_resp_meta",  64'(resp_meta), 64'h77);
        step(); set_req(1, 8'h07, 1'b0, 4'hF, '0, 8'h78); req_valid = 4'b0010;
        @(negedge clk);
        chk("rb_ready", 64'(req_ready), 64'b0010);
        step(); req_valid = '0;
        step();
        @(negedge clk);
        chk("rb_resp_valid", 64'(resp_valid), 64'b0010);
        chk("rb_resp_rdata", 64'(resp_rdata), 64'h0000FFFF);
        chk("rb_resp_meta",  64'(resp_meta), 64'h78);

        // Reset with two buffered and one in-flight response
        step(); resp_ready = '0; set_req(0, 8'h22, 1'b0, 4'hF, '0, 8'h90); req_valid = 4'b0001;
        step(); step();
        step(); req_valid = 4'b1001;
        @(negedge clk);
        chk("pre_rst_valid", 64'(resp_valid), 64'b0001);
        chk("pre_rst_ready", 64'(req_ready), 64'h0);
        #2 rst_i = 1'b1;
        #1;
        chk("mid_rst_resp",     64'(resp_valid), 64'h0);
        chk("mid_rst_bank_req", 64'(bank_req), 64'h0);
        chk("mid_rst_ready",    64'(req_ready), 64'h0);
        step();
        @(negedge clk);
        chk("rst_hold_resp", 64'(resp_valid), 64'h0);
        step(); rst_i = 1'b0; resp_ready = 4'hF;
        @(negedge clk);
        chk("post_rst_grant", 64'(req_ready), 64'b0001);
        chk("post_rst_addr",  64'(bank_addr), 64'h22);
        step(); req_valid = '0;
        repeat (4) step();
        @(negedge clk);
        chk("drain_resp", 64'(resp_valid), 64'h0);
        chk("drain_sb",   64'(sb.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
